// File: rtl/parity_frame_controller.sv
// Word-to-serial framer: start bit, DATA_W data bits LSB first, parity bit, IDLE_BITS stop bits.
// Build option: define PARITY_ODD_EN for odd parity (default is even parity).
module parity_frame_controller #(
   parameter int DATA_W    = 8,
   parameter int IDLE_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              ser_out,
   output logic              par_flag,
   output logic              frame_active,
   output logic              frame_done,
   output logic [7:0]        frame_cnt
);

   localparam int IDX_W = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);
   localparam logic [3:0]       GAP_LAST = 4'(IDLE_BITS);
`ifdef PARITY_ODD_EN
   localparam logic PAR_INV = 1'b1;
`else
   localparam logic PAR_INV = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic              acc_reg, acc_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [3:0]        gap_reg, gap_next;
   logic              ser_reg, ser_next;
   logic              par_reg, par_next;
   logic              active_reg, active_next;
   logic              done_reg, done_next;
   logic [7:0]        cnt_reg, cnt_next;

   assign din_ready    = (state_reg == IDLE) && !rst;
   assign ser_out      = ser_reg;
   assign par_flag     = par_reg;
   assign frame_active = active_reg;
   assign frame_done   = done_reg;
   assign frame_cnt    = cnt_reg;

   // Registered outputs are computed for the state being entered, so they
   // line up with that state's cycle.
   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      acc_next    = acc_reg;
      idx_next    = idx_reg;
      gap_next    = gap_reg;
      ser_next    = 1'b1;
      par_next    = 1'b0;
      active_next = 1'b0;
      done_next   = 1'b0;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (din_valid) begin
               state_next  = START;
               shift_next  = din;
               acc_next    = 1'b0;
               idx_next    = '0;
               ser_next    = 1'b0;
               active_next = 1'b1;
            end
         end
         START: begin
            // Accumulator starts cleared, so the first data bit is its own parity.
            state_next  = DATA;
            ser_next    = shift_reg[0];
            acc_next    = shift_reg[0];
            shift_next  = shift_reg >> 1;
            idx_next    = IDX_W'(1);
            active_next = 1'b1;
         end
         DATA: begin
            active_next = 1'b1;
            if (idx_reg == IDX_LAST) begin
               state_next = PARITY;
               ser_next   = acc_reg ^ PAR_INV;
               par_next   = 1'b1;
            end else begin
               ser_next   = shift_reg[0];
               acc_next   = acc_reg ^ shift_reg[0];
               shift_next = shift_reg >> 1;
               idx_next   = idx_reg + IDX_W'(1);
            end
         end
         PARITY: begin
            state_next  = STOP;
            gap_next    = 4'd1;
            active_next = 1'b1;
            done_next   = (GAP_LAST == 4'd1);
         end
         STOP: begin
            if (gap_reg == GAP_LAST) begin
               state_next = IDLE;
            end else begin
               gap_next    = gap_reg + 4'd1;
               active_next = 1'b1;
               done_next   = ((gap_reg + 4'd1) == GAP_LAST);
            end
         end
         default: state_next = IDLE;
      endcase
      if (done_next) cnt_next = cnt_reg + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         acc_reg    <= 1'b0;
         idx_reg    <= '0;
         gap_reg    <= '0;
         ser_reg    <= 1'b1;
         par_reg    <= 1'b0;
         active_reg <= 1'b0;
         done_reg   <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         acc_reg    <= acc_next;
         idx_reg    <= idx_next;
         gap_reg    <= gap_next;
         ser_reg    <= ser_next;
         par_reg    <= par_next;
         active_reg <= active_next;
         done_reg   <= done_next;
         cnt_reg    <= cnt_next;
      end
   end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Bench for parity_frame_controller: default instance (IDLE_BITS=1) and a
// three-stop-bit instance, checked cycle by cycle against an expected frame built from the word.
module tb_parity_frame_controller;

`ifdef PARITY_ODD_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic       sel;
   logic [7:0] din;

   logic       ready_a, ser_a, parf_a, act_a, done_a;
   logic       ready_b, ser_b, parf_b, act_b, done_b;
   logic [7:0] cnt_a, cnt_b;
   logic       valid_a, valid_b;
   logic       ready, ser, parf, act, done;
   logic [7:0] cnt;

   int vectors = 0;
   int errs    = 0;
   int exp_cnt [2];

   always #5 clk = ~clk;

   assign valid_a = valid & ~sel;
   assign valid_b = valid & sel;
   assign ready   = sel ? ready_b : ready_a;
   assign ser     = sel ? ser_b   : ser_a;
   assign parf    = sel ? parf_b  : parf_a;
   assign act     = sel ? act_b   : act_a;
   assign done    = sel ? done_b  : done_a;
   assign cnt     = sel ? cnt_b   : cnt_a;

   parity_frame_controller #(.DATA_W(8), .IDLE_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .din(din), .din_valid(valid_a), .din_ready(ready_a),
      .ser_out(ser_a), .par_flag(parf_a), .frame_active(act_a),
      .frame_done(done_a), .frame_cnt(cnt_a)
   );

   parity_frame_controller #(.DATA_W(8), .IDLE_BITS(3)) dut_b (
      .clk(clk), .rst(rst), .din(din), .din_valid(valid_b), .din_ready(ready_b),
      .ser_out(ser_b), .par_flag(parf_b), .frame_active(act_b),
      .frame_done(done_b), .frame_cnt(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Sends word w on the selected instance and checks every cycle of its frame.
   // With chain set, valid stays high and nxt is presented for the following frame.
   task automatic frame(input logic [7:0] w, input bit chain, input logic [7:0] nxt);
      int   ib  = sel ? 3 : 1;
      int   len = 10 + ib;
      int   c   = exp_cnt[sel];
      logic par = (($countones(w) % 2) != 0) ^ ODD;
      logic eb;
      din   = w;
      valid = 1'b1;
      check("ready_pre", 32'(ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (chain) din = nxt;
      else begin
         valid = 1'b0;
         din   = 8'($urandom);
      end
      for (int i = 0; i < len; i++) begin
         if (i == 0)      eb = 1'b0;
         else if (i <= 8) eb = w[i-1];
         else if (i == 9) eb = par;
         else             eb = 1'b1;
         check("ser", 32'(ser), 32'(eb));
         check("par_flag", 32'(parf), 32'(i == 9));
         check("active", 32'(act), 32'd1);
         check("done", 32'(done), 32'(i == len - 1));
         check("ready_busy", 32'(ready), 32'd0);
         check("cnt", 32'(cnt), (i == len - 1) ? 32'((c + 1) % 256) : 32'(c));
         @(negedge clk);
      end
      exp_cnt[sel] = (c + 1) % 256;
      check("ready_post", 32'(ready), 32'd1);
      check("idle_ser", 32'(ser), 32'd1);
      check("idle_active", 32'(act), 32'd0);
      check("cnt_post", 32'(cnt), 32'(exp_cnt[sel]));
   endtask

   initial begin
      logic [7:0] cur, nxt;
      bit         ch;
      rst = 1'b1; valid = 1'b0; din = 8'h00; sel = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      repeat (2) @(negedge clk);
      check("rst_ser", 32'(ser), 32'd1);
      check("rst_par", 32'(parf), 32'd0);
      check("rst_active", 32'(act), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      rst = 1'b0;
      #1 check("ready_after_rst", 32'(ready), 32'd1);

      frame(8'hA5, 1'b0, 8'h00);
      frame(8'h07, 1'b0, 8'h00);
      frame(8'h00, 1'b0, 8'h00);
      frame(8'hFF, 1'b0, 8'h00);
      frame(8'h3C, 1'b1, 8'hC3);
      frame(8'hC3, 1'b0, 8'h00);

      // abort during the 4th data bit
      din = 8'hA5; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_bit3", 32'(ser), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ser", 32'(ser), 32'd1);
      check("abort_active", 32'(act), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_cnt", 32'(cnt), 32'd0);
      check("abort_ready", 32'(ready), 32'd0);
      exp_cnt[0] = 0;
      rst = 1'b0;
      #1 check("abort_ready_rel", 32'(ready), 32'd1);
      frame(8'h01, 1'b0, 8'h00);

      cur = 8'($urandom);
      for (int k = 0; k < 20; k++) begin
         nxt = 8'($urandom);
         ch  = (k != 19) && ($urandom_range(0, 1) == 1);
         frame(cur, ch, nxt);
         if (ch) cur = nxt;
         else begin
            cur = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end

      sel = 1'b1;
      #1;
      for (int k = 0; k < 256; k++) frame(8'h55, (k != 255), 8'h55);
      check("wrap_cnt", 32'(cnt_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
